// File: rtl/store_data_pkg.sv
// Shared types and constants for the store data writer: FSM states, line geometry
// and the element-granular shift used to align segments onto memory lines.
package store_data_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE1 = 2'd1,
        WRITE2 = 2'd2
    } state_t;

    localparam int MASK_W    = 32;
    localparam int ELEM_BITS = 8;
    localparam int LINE_BITS = MASK_W * ELEM_BITS;
    localparam int OFF_W     = $clog2(MASK_W);
    localparam int IDX_W     = OFF_W + 1;

    // Shift a line by whole elements; up moves element i to i+amt, down to i-amt.
    function automatic logic [LINE_BITS-1:0] shift_elems(
        input logic [LINE_BITS-1:0] data,
        input logic [IDX_W-1:0]     amt,
        input logic                 up
    );
        logic [LINE_BITS-1:0] result;
        if (up) begin
            result = data << (int'(amt) * ELEM_BITS);
        end else begin
            result = data >> (int'(amt) * ELEM_BITS);
        end
        return result;
    endfunction

endpackage

// File: rtl/store_mask_gen.sv
// Combinational element mask: bit i is set when lo <= i < hi.
module store_mask_gen
    import store_data_pkg::*;
(
    input  logic [IDX_W-1:0]  lo,
    input  logic [IDX_W-1:0]  hi,
    output logic [MASK_W-1:0] mask
);

    always_comb begin
        mask = '0;
        for (int i = 0; i < MASK_W; i++) begin
            mask[i] = (IDX_W'(i) >= lo) && (IDX_W'(i) < hi);
        end
    end

endmodule

// File: rtl/store_data_writer.sv
// Writes a pointer-addressed segment into line memory, splitting line-crossing segments
// into two masked writes. Define STORE_DATA_STATS_EN to build the line/split counters.
module store_data_writer
    import store_data_pkg::*;
#(
    parameter int DATA_WRITE_WIDTH = MASK_W,
    parameter int ELEM_WIDTH       = ELEM_BITS,
    parameter int POINTER_WIDTH    = 30,
    parameter int ADDR_WIDTH       = 21
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [POINTER_WIDTH-1:0]             in_pointer,
    input  logic [10:0]                          in_len,
    input  logic [DATA_WRITE_WIDTH*ELEM_WIDTH-1:0] in_data,
    output logic                                 wr_valid,
    input  logic                                 wr_ready,
    output logic [ADDR_WIDTH-1:0]                wr_addr,
    output logic [DATA_WRITE_WIDTH*ELEM_WIDTH-1:0] wr_data,
    output logic [DATA_WRITE_WIDTH-1:0]          wr_mask,
    output logic                                 err_len,
    output logic [31:0]                          wr_line_count,
    output logic [31:0]                          split_count
);

    // Handshakes: a transfer happens on a clock edge where valid && ready; valid never
    // waits on ready, and wr_* hold stable while wr_valid is high without wr_ready.

    state_t state, state_next;

    logic                   accept;
    logic [OFF_W-1:0]       off_in;
    logic [ADDR_WIDTH-1:0]  base_in;
    logic [10:0]            len_in;
    logic [11:0]            end_in;
    logic                   split_in;
    logic                   start;
    logic [IDX_W-1:0]       hi_first;

    logic [LINE_BITS-1:0]   data_q;
    logic [OFF_W-1:0]       off_q;
    logic                   split_q;
    logic [IDX_W-1:0]       hi2_q;

    logic [IDX_W-1:0]       mask_lo;
    logic [IDX_W-1:0]       mask_hi;
    logic [MASK_W-1:0]      mask_next;

    logic                   unused_ptr_bits;

    assign accept   = in_valid && in_ready;
    assign off_in   = in_pointer[OFF_W-1:0];
    assign base_in  = in_pointer[OFF_W +: ADDR_WIDTH];
    assign len_in   = (in_len > 11'(DATA_WRITE_WIDTH)) ? 11'(DATA_WRITE_WIDTH) : in_len;
    assign end_in   = 12'(off_in) + 12'(len_in);
    assign split_in = end_in > 12'(DATA_WRITE_WIDTH);
    assign start    = accept && (len_in != 11'd0);
    assign hi_first = split_in ? IDX_W'(DATA_WRITE_WIDTH) : end_in[IDX_W-1:0];

    assign unused_ptr_bits = ^in_pointer[POINTER_WIDTH-1:OFF_W+ADDR_WIDTH];

    // One mask generator serves both halves: first range at accept, second from WRITE1.
    assign mask_lo = (state == IDLE) ? IDX_W'(off_in) : '0;
    assign mask_hi = (state == IDLE) ? hi_first : hi2_q;

    store_mask_gen u_mask_gen (
        .lo   (mask_lo),
        .hi   (mask_hi),
        .mask (mask_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        wr_valid   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (start) state_next = WRITE1;
            end
            WRITE1: begin
                wr_valid = 1'b1;
                if (wr_ready) state_next = split_q ? WRITE2 : IDLE;
            end
            WRITE2: begin
                wr_valid = 1'b1;
                if (wr_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr <= '0;
            wr_data <= '0;
            wr_mask <= '0;
            err_len <= 1'b0;
            data_q  <= '0;
            off_q   <= '0;
            split_q <= 1'b0;
            hi2_q   <= '0;
        end else begin
            err_len <= accept && (in_len > 11'(DATA_WRITE_WIDTH));
            if (start) begin
                data_q  <= in_data;
                off_q   <= off_in;
                split_q <= split_in;
                hi2_q   <= IDX_W'(end_in - 12'(DATA_WRITE_WIDTH));
                wr_addr <= base_in;
                wr_data <= shift_elems(in_data, IDX_W'(off_in), 1'b1);
                wr_mask <= mask_next;
            end else if (state == WRITE1 && wr_ready && split_q) begin
                wr_addr <= wr_addr + ADDR_WIDTH'(1);
                wr_data <= shift_elems(data_q, IDX_W'(DATA_WRITE_WIDTH) - IDX_W'(off_q), 1'b0);
                wr_mask <= mask_next;
            end
        end
    end

`ifdef STORE_DATA_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_line_count <= '0;
            split_count   <= '0;
        end else begin
            if (wr_valid && wr_ready) wr_line_count <= wr_line_count + 32'd1;
            if (accept && split_in)   split_count   <= split_count + 32'd1;
        end
    end
`else
    assign wr_line_count = '0;
    assign split_count   = '0;
`endif

endmodule

// File: tb/tb_store_data_writer.sv
// Self-checking bench for store_data_writer: directed cases plus random segments,
// with a scoreboard of expected line writes built from an element-by-element model.
module tb_store_data_writer;

    localparam int W   = 32;
    localparam int EB  = 8;
    localparam int DW  = W * EB;
    localparam int AW  = 21;
    localparam int PTW = 30;
    localparam int EXW = AW + W + DW;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [PTW-1:0] in_pointer;
    logic [10:0]    in_len;
    logic [DW-1:0]  in_data;
    logic           wr_valid;
    logic           wr_ready;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  wr_data;
    logic [W-1:0]   wr_mask;
    logic           err_len;
    logic [31:0]    wr_line_count;
    logic [31:0]    split_count;

    logic [EXW-1:0] exp_q[$];
    int checks      = 0;
    int failures    = 0;
    int err_seen    = 0;
    int valid_cycles = 0;
    int lines_seen  = 0;
    int exp_splits  = 0;

    store_data_writer dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pointer    (in_pointer),
        .in_len        (in_len),
        .in_data       (in_data),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_mask       (wr_mask),
        .err_len       (err_len),
        .wr_line_count (wr_line_count),
        .split_count   (split_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // Element-by-element reference placement of one segment.
    task automatic model(input logic [PTW-1:0] ptr, input logic [10:0] len,
                         input logic [DW-1:0] d, input bit push_second);
        int off, n, pos;
        logic [AW-1:0] base;
        logic [DW-1:0] d1, d2;
        logic [W-1:0]  m1, m2;
        off  = int'(ptr % W);
        base = AW'(ptr / W);
        n    = (len > 11'(W)) ? W : int'(len);
        if (n == 0) return;
        d1 = '0; d2 = '0; m1 = '0; m2 = '0;
        for (int j = 0; j < W; j++) begin
            if (j >= off) d1[j*EB +: EB] = d[(j-off)*EB +: EB];
            if (j + W - off < W) d2[j*EB +: EB] = d[(j+W-off)*EB +: EB];
        end
        for (int k = 0; k < n; k++) begin
            pos = off + k;
            if (pos < W) m1[pos] = 1'b1;
            else         m2[pos-W] = 1'b1;
        end
        exp_q.push_back({base, m1, d1});
        if (off + n > W) begin
            exp_splits++;
            if (push_second) exp_q.push_back({base + AW'(1), m2, d2});
        end
    endtask

    task automatic send(input logic [PTW-1:0] ptr, input logic [10:0] len,
                        input logic [DW-1:0] d, input bit push_second);
        int guard = 0;
        @(posedge clk); #1;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) check("send_timeout", 320'(guard < 100), 320'(1));
        in_valid   = 1'b1;
        in_pointer = ptr;
        in_len     = len;
        in_data    = d;
        model(ptr, len, d, push_second);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = rand_line();
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain", 320'(exp_q.size()), 320'(0));
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every completed memory write must match the next expected line.
    always @(negedge clk) begin
        if (!rst) begin
            if (err_len) err_seen++;
            if (wr_valid) valid_cycles++;
            if (wr_valid && wr_ready) begin
                lines_seen++;
                check("pending_exp", 320'(exp_q.size() != 0), 320'(1));
                if (exp_q.size() != 0) check("wr_line", 320'({wr_addr, wr_mask, wr_data}), 320'(exp_q.pop_front()));
            end
        end else begin
            lines_seen = 0;
        end
    end

    initial begin
        logic [DW-1:0] d;
        logic [EXW-1:0] snap;
        int vc, es;

        rst = 1'b1; in_valid = 1'b0; in_pointer = '0; in_len = '0; in_data = '0; wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", 320'(in_ready), 320'(1));
        check("rst_wr_valid", 320'(wr_valid), 320'(0));
        check("rst_wr_line",  320'({wr_addr, wr_mask, wr_data}), 320'(0));
        check("rst_err_len",  320'(err_len), 320'(0));
        check("rst_counts",   320'({wr_line_count, split_count}), 320'(0));

        // In-line write, 2-cycle turnaround
        d = rand_line();
        send(30'd70, 11'd10, d, 1'b1);
        check("t1_in_ready_low", 320'(in_ready), 320'(0));
        check("t1_addr", 320'(wr_addr), 320'(2));
        check("t1_mask", 320'(wr_mask), 320'(32'h0000FFC0));
        @(posedge clk); #1;
        check("t1_in_ready_back", 320'(in_ready), 320'(1));
        drain();

        // Line-crossing split
        send(30'd60, 11'd8, rand_line(), 1'b1);
        check("t2_addr1", 320'(wr_addr), 320'(1));
        check("t2_mask1", 320'(wr_mask), 320'(32'hF0000000));
        @(posedge clk); #1;
        check("t2_addr2", 320'(wr_addr), 320'(2));
        check("t2_mask2", 320'(wr_mask), 320'(32'h0000000F));
        check("t2_busy", 320'(in_ready), 320'(0));
        drain();
`ifdef STORE_DATA_STATS_EN
        check("t2_split_count", 320'(split_count), 320'(1));
`else
        check("t2_split_count_off", 320'(split_count), 320'(0));
`endif

        // Exact boundary fill: single write
        send(30'd64, 11'd32, rand_line(), 1'b1);
        check("t3_mask", 320'(wr_mask), 320'(32'hFFFFFFFF));
        @(posedge clk); #1;
        check("t3_no_write2", 320'(in_ready), 320'(1));
        drain();

        // Backpressure on a split request
        wr_ready = 1'b0;
        send(30'd125, 11'd20, rand_line(), 1'b1);
        @(negedge clk);
        check("bp_valid", 320'(wr_valid), 320'(1));
        snap = {wr_addr, wr_mask, wr_data};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_stable", 320'({wr_addr, wr_mask, wr_data}), 320'(snap));
        end
        @(posedge clk); #1;
        wr_ready = 1'b1;
        drain();

        // Zero length: accepted, nothing written
        vc = valid_cycles;
        send(30'd33, 11'd0, rand_line(), 1'b1);
        check("len0_in_ready", 320'(in_ready), 320'(1));
        repeat (3) @(posedge clk);
        #1 check("len0_no_write", 320'(valid_cycles), 320'(vc));

        // Over-length clamps to a full line and flags once
        es = err_seen;
        send(30'd128, 11'd40, rand_line(), 1'b1);
        check("len40_err_now", 320'(err_len), 320'(1));
        check("len40_mask", 320'(wr_mask), 320'(32'hFFFFFFFF));
        drain();
        check("len40_err_once", 320'(err_seen - es), 320'(1));

        // Address wrap on the second half
        send(30'((((1 << 21) - 1) * 32) + 4), 11'd32, rand_line(), 1'b1);
        @(posedge clk); #1;
        check("wrap_addr2", 320'(wr_addr), 320'(0));
        drain();

        // Reset while the second half is pending
        send(30'd300, 11'd30, rand_line(), 1'b0);
        @(posedge clk); #1;
        check("rst2_in_write2", 320'(wr_valid), 320'(1));
        wr_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst2_valid_low", 320'(wr_valid), 320'(0));
        check("rst2_in_ready", 320'(in_ready), 320'(1));
        rst = 1'b0;
        wr_ready = 1'b1;
        exp_splits = 0;
        vc = valid_cycles;
        repeat (5) @(posedge clk);
        #1 check("rst2_no_second", 320'(valid_cycles), 320'(vc));
        check("rst2_queue_empty", 320'(exp_q.size()), 320'(0));

        // Random segments with mixed backpressure
        for (int n = 0; n < 12; n++) begin
            wr_ready = ($urandom_range(0, 1) == 1);
            send(30'($urandom_range(0, 32'h3FFF_FFFF)), 11'($urandom_range(0, 36)), rand_line(), 1'b1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1 wr_ready = 1'b1;
            drain();
        end

`ifdef STORE_DATA_STATS_EN
        check("stats_lines",  320'(wr_line_count), 320'(lines_seen));
        check("stats_splits", 320'(split_count), 320'(exp_splits));
`else
        check("stats_off", 320'({wr_line_count, split_count}), 320'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_data_writer.md
Name: store_data_writer

Overview:
- Write-side counterpart of the load data path: takes a variable-length data segment addressed by an element pointer and writes it into the line-organised data memory.
- Each line holds DATA_WRITE_WIDTH elements; the segment is placed at its element offset with a per-element write mask.
- A segment that crosses a line boundary is split into two masked line writes on consecutive cycles.
- Sits between the PE result collector (upstream) and the data-memory write port (downstream).

Parameters:
- DATA_WRITE_WIDTH, 32: elements per memory line; power of two.
- ELEM_WIDTH, 8: bits per element.
- POINTER_WIDTH, 30: width of the element pointer.
- ADDR_WIDTH, 21: width of the line address.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  segment request valid.
- in_ready  out  1  block can accept a segment.
- in_pointer  in  POINTER_WIDTH  element pointer of the first element.
- in_len  in  11  element count.
- in_data  in  DATA_WRITE_WIDTH*ELEM_WIDTH  segment elements, element 0 at bits [ELEM_WIDTH-1:0].
- wr_valid  out  1  memory write valid.
- wr_ready  in  1  memory accepts the write.
- wr_addr  out  ADDR_WIDTH  line address.
- wr_data  out  DATA_WRITE_WIDTH*ELEM_WIDTH  line data, already aligned to the line.
- wr_mask  out  DATA_WRITE_WIDTH  per-element write enable.
- err_len  out  1  one-cycle pulse: in_len > DATA_WRITE_WIDTH was seen.
- wr_line_count  out  32  lines written; only meaningful with the optional feature.
- split_count  out  32  segments that were split; only meaningful with the optional feature.

Behaviour:

Reset values:
- All outputs are 0 except in_ready, which is 1.
- The state machine resets to IDLE.

State machine (IDLE, WRITE1, WRITE2):
- in_ready = (state == IDLE).
- A segment is accepted when in_valid && in_ready.

Segment arithmetic on accept (W = DATA_WRITE_WIDTH):
- off = in_pointer % W; base = in_pointer / W.
- len = min(in_len, W).
- end = off + len, computed at 12 bits.

Clamping and zero length:
- If in_len > W: len is clamped to W, err_len pulses for 1 cycle, and processing continues normally.
- If len == 0: the segment is accepted, no write is issued, and state stays IDLE.

First write (IDLE -> WRITE1, registered):
- wr_valid rises on the cycle after accept.
- wr_addr = base.
- wr_data = in_data shifted up by off elements.
- wr_mask has bits [off, min(end, W)-1] set.
- Need-split flag = (end > W). end == W exactly is not a split.

WRITE1, when wr_ready:
- If split: go to WRITE2 next cycle with:
  - wr_addr = base+1, wrapping modulo 2^ADDR_WIDTH;
  - wr_data = in_data shifted down by (W-off) elements;
  - wr_mask has bits [0, end-W-1] set.
- If not split: go to IDLE and drop wr_valid.

WRITE2, when wr_ready: go to IDLE and drop wr_valid.

Backpressure:
- While wr_valid && !wr_ready, wr_addr, wr_data and wr_mask hold stable.
- Segment data is captured at accept, so upstream may change in_data after acceptance.

Throughput and latency:
- Non-split segment: 1 per 2 cycles. Split segment: 1 per 3 cycles.
- Latency from accept to first wr_valid: 1 cycle.

Reset mid-operation:
- Any state returns to IDLE on the next clock with wr_valid = 0.
- A pending second half is discarded.

Optional Feature:
- Macro STORE_DATA_STATS_EN.
- When defined:
  - wr_line_count increments on every wr_valid && wr_ready;
  - split_count increments on every accepted segment with end > W;
  - both counters wrap at 2^32 and clear on rst.
- When not defined: both ports are tied to 0 and no counter logic is built.

Decomposition:
- Package store_data_pkg holds:
  - the state enum (IDLE, WRITE1, WRITE2);
  - the mask-width and element-count constants;
  - a helper function for the element-granular shift.
- One sub-module, store_mask_gen, is natural: a combinational mask of bits [lo, hi) from lo/hi inputs, instantiated once and muxed between the first-write and second-write ranges.

Test Plan (W=32, ELEM_WIDTH=8):
- Simple in-line write: pointer=70, len=10, wr_ready=1 -> one write, addr=2, mask=0x0000FFC0, in_data bytes 0..9 appear at bytes 6..15; in_ready back to 1 two cycles after accept.
- Line-crossing split: pointer=60, len=8 -> two writes:
  - addr=1, mask=0xF0000000, elements 0..3 at bytes 28..31;
  - addr=2, mask=0x0000000F, elements 4..7 at bytes 0..3;
  - split_count=1 with STORE_DATA_STATS_EN.
- Exact-boundary fill: pointer=64, len=32 -> single write, addr=2, mask=0xFFFFFFFF, no WRITE2.
- Backpressure: split request with wr_ready low for 3 cycles in WRITE1 -> wr_addr, wr_data and wr_mask unchanged across those cycles; second write follows only after the handshake.
- Length edge cases:
  - len=0 -> no wr_valid, and in_ready stays 1;
  - len=40 -> err_len pulses once and a 32-element write is issued;
  - pointer=(2^21-1)*32+4, len=32 -> second write wraps to addr=0.
- Reset in WRITE2: assert rst -> next cycle wr_valid=0, in_ready=1, no second-half write is ever issued.
